// File: rtl/elastic_sr_pkg.sv
// Shared constants and sizing helper for the elastic shift register.
// ELASTIC_SR_DATA_CLEAR_EN (optional macro) zeroes payload in empty stages.
package elastic_sr_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 8;

    // Bits needed to count 0..n_stages inclusive.
    function automatic int occ_width(input int n_stages);
        return $clog2(n_stages + 1);
    endfunction

endpackage

// File: rtl/elastic_sr_stage.sv
// One valid/payload slot of the elastic delay line; ready is ~vld | downstream ready.
// With ELASTIC_SR_DATA_CLEAR_EN defined, the payload is zeroed whenever the slot goes empty.
module elastic_sr_stage
    import elastic_sr_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_vld,
    input  logic [width-1:0] up_data,
    input  logic             dn_rdy,
    output logic             rdy,
    output logic             vld,
    output logic [width-1:0] data
);

    logic             vld_reg;
    logic [width-1:0] data_reg;

    assign rdy  = ~vld_reg | dn_rdy;
    assign vld  = vld_reg;
    assign data = data_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_reg  <= 1'b0;
            data_reg <= '0;
        end else if (flush) begin
            vld_reg  <= 1'b0;
`ifdef ELASTIC_SR_DATA_CLEAR_EN
            data_reg <= '0;
`endif
        end else if (rdy) begin
            vld_reg  <= up_vld;
`ifdef ELASTIC_SR_DATA_CLEAR_EN
            data_reg <= up_vld ? up_data : '0;
`else
            if (up_vld) begin
                data_reg <= up_data;
            end
`endif
        end
    end

endmodule

// File: rtl/elastic_shift_register.sv
// Fixed-depth delay line with valid/ready on both sides; bubbles collapse under backpressure.
// Optional ELASTIC_SR_DATA_CLEAR_EN forces out_data to 0 while out_vld is low.
module elastic_shift_register
    import elastic_sr_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH,
    parameter int depth = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [width-1:0]             in_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [width-1:0]             out_data,
    output logic [occ_width(depth)-1:0]  occupancy
);

    localparam int OCC_W = occ_width(depth);

    logic [depth-1:0] stage_vld;
    logic [width-1:0] stage_data [depth];
    logic             in_xfer;
    logic             out_xfer;
    logic [OCC_W-1:0] occupancy_reg;
    logic [OCC_W-1:0] occupancy_next;

    // Ready is kept as one signal per generate block so the combinational
    // ready chain never loops back through a single shared vector.
    for (genvar gi = 0; gi < depth; gi++) begin : g_stage
        logic             up_vld;
        logic [width-1:0] up_data;
        logic             dn_rdy;
        logic             rdy;

        if (gi == 0) begin : g_head
            assign up_vld  = in_vld;
            assign up_data = in_data;
        end else begin : g_link
            assign up_vld  = stage_vld[gi-1];
            assign up_data = stage_data[gi-1];
        end

        if (gi == depth - 1) begin : g_tail
            assign dn_rdy = out_rdy;
        end else begin : g_mid
            assign dn_rdy = g_stage[gi+1].rdy;
        end

        elastic_sr_stage #(
            .width (width)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .up_vld  (up_vld),
            .up_data (up_data),
            .dn_rdy  (dn_rdy),
            .rdy     (rdy),
            .vld     (stage_vld[gi]),
            .data    (stage_data[gi])
        );
    end

    assign in_rdy   = g_stage[0].rdy & ~flush;
    assign out_vld  = stage_vld[depth-1] & ~flush;
    assign in_xfer  = in_vld & in_rdy;
    assign out_xfer = out_vld & out_rdy;

`ifdef ELASTIC_SR_DATA_CLEAR_EN
    assign out_data = out_vld ? stage_data[depth-1] : '0;
`else
    assign out_data = stage_data[depth-1];
`endif

    always_comb begin
        occupancy_next = occupancy_reg;
        if (flush) begin
            occupancy_next = '0;
        end else if (in_xfer && !out_xfer) begin
            occupancy_next = occupancy_reg + OCC_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occupancy_next = occupancy_reg - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy_reg <= '0;
        end else begin
            occupancy_reg <= occupancy_next;
        end
    end

    assign occupancy = occupancy_reg;

endmodule
